// File: rtl/counterab_pkg.sv
// Shared types, default stream limits and next-value helpers for the
// counter-stream checker.
package counterab_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int A_MAX_D = 12;
    localparam int B_TOP_D = 15;

    function automatic logic [3:0] next_up(input logic [3:0] prev, input logic [3:0] wrap);
        return (prev == wrap) ? 4'd0 : prev + 4'd1;
    endfunction

    function automatic logic [3:0] next_down(input logic [3:0] prev, input logic [3:0] top);
        return (prev == 4'd0) ? top : prev - 4'd1;
    endfunction

endpackage

// File: rtl/seq_chk_chan.sv
// One counter-stream channel: hunts for LOCK_CNT consecutive correct steps,
// then flags and counts any broken step while locked.
module seq_chk_chan
    import counterab_pkg::*;
#(
    parameter bit DIR      = 1'b0,
    parameter int WRAP     = A_MAX_D,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       samp_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [3:0]       WRAP_V  = 4'(WRAP);
    localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    ONE_M   = MW'(1);
    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ONE_E   = ERR_W'(1);

    logic [3:0]       prev_q;
    logic             prev_vld_q;
    logic [MW-1:0]    match_cnt_q;
    chk_state_t       state_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;
    logic [3:0]       exp_val;
    logic             is_match;

    // Out-of-range samples can never match, even if they equal the expected value.
    always_comb begin
        exp_val   = DIR ? next_down(prev_q, WRAP_V) : next_up(prev_q, WRAP_V);
        is_match  = (samp_i <= WRAP_V) && (samp_i == exp_val);
        err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + ONE_E;
    end

    // Hunt/lock FSM with reference update, error pulse and saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 4'd0;
            prev_vld_q  <= 1'b0;
            match_cnt_q <= '0;
            state_q     <= HUNT;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            prev_q     <= samp_i;
            prev_vld_q <= 1'b1;
            err_q      <= 1'b0;
            if (prev_vld_q) begin
                case (state_q)
                    HUNT: begin
                        if (is_match) begin
                            match_cnt_q <= match_cnt_q + ONE_M;
                            if ((match_cnt_q + ONE_M) == LOCK_V) begin
                                state_q <= LOCKED;
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_match) begin
                            state_q     <= HUNT;
                            match_cnt_q <= '0;
                            err_q       <= 1'b1;
                            err_cnt_q   <= err_cnt_d;
                        end
                    end
                    default: begin
                        state_q     <= HUNT;
                        match_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/counterab_checker.sv
// Checks an up-counting A stream and a down-counting B stream independently
// and pulses sync at the start of their joint period.
module counterab_checker
    import counterab_pkg::*;
#(
    parameter int A_MAX    = A_MAX_D,
    parameter int B_TOP    = B_TOP_D,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       a_in,
    input  logic [3:0]       b_in,
    output logic             a_locked,
    output logic             b_locked,
    output logic             a_err,
    output logic             b_err,
    output logic [ERR_W-1:0] a_err_cnt,
    output logic [ERR_W-1:0] b_err_cnt,
    output logic             sync
);

    localparam logic [3:0] B_TOP_V = 4'(B_TOP);

    logic sync_q;

    seq_chk_chan #(
        .DIR      (1'b0),
        .WRAP     (A_MAX),
        .LOCK_CNT (LOCK_CNT),
        .ERR_W    (ERR_W)
    ) u_chan_a (
        .clk       (clk),
        .rst       (rst),
        .samp_i    (a_in),
        .locked_o  (a_locked),
        .err_o     (a_err),
        .err_cnt_o (a_err_cnt)
    );

    seq_chk_chan #(
        .DIR      (1'b1),
        .WRAP     (B_TOP),
        .LOCK_CNT (LOCK_CNT),
        .ERR_W    (ERR_W)
    ) u_chan_b (
        .clk       (clk),
        .rst       (rst),
        .samp_i    (b_in),
        .locked_o  (b_locked),
        .err_o     (b_err),
        .err_cnt_o (b_err_cnt)
    );

    // Lock state here is the pre-edge state, so sync needs both locked beforehand.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= (a_in == 4'd0) && (b_in == B_TOP_V) && a_locked && b_locked;
        end
    end

    assign sync = sync_q;

endmodule

// File: tb/tb_counterab_checker.sv
// Self-checking bench: directed vector table plus long-run sync and
// counter-saturation sequences.
module tb_counterab_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a_in = 4'd0;
    logic [3:0] b_in = 4'd0;
    logic       a_locked, b_locked, a_err, b_err, sync;
    logic [7:0] a_err_cnt, b_err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] flags;   // {a_locked, b_locked, a_err, b_err, sync}
        logic [7:0] aec;
        logic [7:0] bec;
    } vec_t;

    vec_t vq[$];

    counterab_checker #(
        .A_MAX(12), .B_TOP(15), .LOCK_CNT(4), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .a_locked(a_locked), .b_locked(b_locked),
        .a_err(a_err), .b_err(b_err),
        .a_err_cnt(a_err_cnt), .b_err_cnt(b_err_cnt),
        .sync(sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b);
        rst  = r;
        a_in = a;
        b_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input int a, input int b,
                       input logic al, input logic bl, input logic ae, input logic be,
                       input int aec, input int bec, input logic sy);
        vec_t v;
        v.r     = r;
        v.a     = 4'(a);
        v.b     = 4'(b);
        v.flags = {al, bl, ae, be, sy};
        v.aec   = 8'(aec);
        v.bec   = 8'(bec);
        vq.push_back(v);
    endtask

    initial begin
        int av;
        int bv;
        int exp_cnt;
        #1;

        // Reset, load, 4 matches -> lock; ideal run up to B reaching 0
        add(1'b1, 0, 0,   1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 0, 15,  1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 1, 14,  1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 2, 13,  1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 3, 12,  1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 4, 11,  1'b1,1'b1,1'b0,1'b0, 0,0, 1'b0);
        for (int e = 6; e <= 16; e++)
            add(1'b0, (e-1) % 13, 15 - ((e-1) % 16), 1'b1,1'b1,1'b0,1'b0, 0,0, 1'b0);
        // A gets 7 where 3 is expected; B wraps 0->15 as a match
        add(1'b0, 7, 15,  1'b0,1'b1,1'b1,1'b0, 1,0, 1'b0);
        add(1'b0, 8, 14,  1'b0,1'b1,1'b0,1'b0, 1,0, 1'b0);
        add(1'b0, 9, 13,  1'b0,1'b1,1'b0,1'b0, 1,0, 1'b0);
        add(1'b0, 10, 12, 1'b0,1'b1,1'b0,1'b0, 1,0, 1'b0);
        add(1'b0, 11, 11, 1'b1,1'b1,1'b0,1'b0, 1,0, 1'b0);
        add(1'b0, 12, 10, 1'b1,1'b1,1'b0,1'b0, 1,0, 1'b0);
        add(1'b0, 0, 9,   1'b1,1'b1,1'b0,1'b0, 1,0, 1'b0);
        for (int k = 0; k <= 8; k++)
            add(1'b0, 1 + k, 8 - k, 1'b1,1'b1,1'b0,1'b0, 1,0, 1'b0);
        // B 0->0 error, then A 12->13 error
        add(1'b0, 10, 0,  1'b1,1'b0,1'b0,1'b1, 1,1, 1'b0);
        add(1'b0, 11, 15, 1'b1,1'b0,1'b0,1'b0, 1,1, 1'b0);
        add(1'b0, 12, 14, 1'b1,1'b0,1'b0,1'b0, 1,1, 1'b0);
        add(1'b0, 13, 13, 1'b0,1'b0,1'b1,1'b0, 2,1, 1'b0);
        // Out-of-range in HUNT clears progress without flagging
        add(1'b0, 13, 12, 1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 0, 11,  1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 1, 10,  1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 2, 9,   1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 13, 8,  1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 0, 7,   1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 1, 6,   1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 2, 5,   1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 3, 4,   1'b0,1'b1,1'b0,1'b0, 2,1, 1'b0);
        add(1'b0, 4, 3,   1'b1,1'b1,1'b0,1'b0, 2,1, 1'b0);
        // Reset while both locked, relock after 5 samples
        add(1'b1, 5, 2,   1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 6, 1,   1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 7, 0,   1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 8, 15,  1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 9, 14,  1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0);
        add(1'b0, 10, 13, 1'b1,1'b1,1'b0,1'b0, 0,0, 1'b0);
        // Simultaneous errors on both channels
        add(1'b0, 3, 3,   1'b0,1'b0,1'b1,1'b1, 1,1, 1'b0);
        add(1'b0, 4, 2,   1'b0,1'b0,1'b0,1'b0, 1,1, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].r, vq[i].a, vq[i].b);
            chk($sformatf("row%0d_flags", i), {3'b000, a_locked, b_locked, a_err, b_err, sync},
                {3'b000, vq[i].flags});
            chk($sformatf("row%0d_a_err_cnt", i), a_err_cnt, vq[i].aec);
            chk($sformatf("row%0d_b_err_cnt", i), b_err_cnt, vq[i].bec);
        end

        // Ideal streams: sync after edges 209 and 417 only (joint period 208)
        drive(1'b1, 4'd0, 4'd0);
        for (int e = 1; e <= 420; e++) begin
            drive(1'b0, 4'((e-1) % 13), 4'(15 - ((e-1) % 16)));
            chk($sformatf("sync_e%0d", e), {7'd0, sync}, {7'd0, ((e == 209) || (e == 417))});
            if (e == 4 || e == 5)
                chk($sformatf("lock_e%0d", e), {6'd0, a_locked, b_locked}, (e == 5) ? 8'd3 : 8'd0);
        end
        chk("ideal_a_err_cnt", a_err_cnt, 8'd0);
        chk("ideal_b_err_cnt", b_err_cnt, 8'd0);

        // 300 locked B mismatches: counter saturates at 255
        drive(1'b1, 4'd0, 4'd0);
        av = 0;
        bv = 15;
        for (int s = 0; s < 5; s++) begin
            drive(1'b0, 4'(av), 4'(bv));
            av = (av == 12) ? 0 : av + 1;
            bv = (bv == 0) ? 15 : bv - 1;
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 4'(av), 4'((bv == 15) ? 0 : bv + 1));
            bv = (bv == 15) ? 0 : bv + 1;
            av = (av == 12) ? 0 : av + 1;
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            chk($sformatf("sat_err_%0d", i), {7'd0, b_err}, 8'd1);
            chk($sformatf("sat_cnt_%0d", i), b_err_cnt, 8'(exp_cnt));
            for (int s = 0; s < 4; s++) begin
                bv = (bv == 0) ? 15 : bv - 1;
                drive(1'b0, 4'(av), 4'(bv));
                av = (av == 12) ? 0 : av + 1;
            end
            chk($sformatf("sat_relock_%0d", i), {7'd0, b_locked}, 8'd1);
        end
        chk("sat_final_b", b_err_cnt, 8'd255);
        chk("sat_final_a", a_err_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
